ws2801_receiver: RTL
====================

WS2801_RECEIVER -- requirements
Module: ws2801_receiver

Interface
REQ-001 Parameter LATCH_CYCLES, default 6250, means clk cycles of continuous cki low before latch (500 us at 12.5 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, means flip-flop depth of input synchronizers; legal range 2..3.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cki  input  1  WS2801 serial clock from upstream, asynchronous to clk.
REQ-006 sdi  input  1  WS2801 serial data from upstream, asynchronous to clk.
REQ-007 cko  output  1  forwarded serial clock to downstream LED.
REQ-008 sdo  output  1  forwarded serial data to downstream LED.
REQ-009 rgb  output  24  latched colour, bit 23 = first bit received.
REQ-010 rgbValid  output  1  one-cycle pulse when rgb updates.
REQ-011 frameError  output  1  one-cycle pulse when a partial word (1..23 bits) is discarded at latch.

Function
REQ-012 cki and sdi SHALL each pass through SYNC_STAGES flip-flops before any use; an edge detector on synced cki SHALL produce ckiRise.
REQ-013 On ckiRise with bitCount < 24, the synced sdi SHALL shift into shiftReg LSB, shifting left (MSB-first), and bitCount SHALL increment.
REQ-014 On ckiRise with bitCount == 24 the block SHALL be in forwarding mode; bitCount SHALL saturate at 24.
REQ-015 Forwarding SHALL become true on the cycle bitCount reaches 24 and remain true until latch.
REQ-016 cko SHALL be a register of (forwarding AND synced cki); sdo SHALL be a register of (forwarding ? synced sdi : 0), so that cko and sdo are cycle-aligned.
REQ-017 The 24th bit's own cki pulse SHALL NOT be forwarded; only the first pulse after forwarding is set and later pulses appear on cko.
REQ-018 Pin-to-shift latency SHALL be SYNC_STAGES+1 clk cycles; cki-pin-to-cko latency SHALL be SYNC_STAGES+1 cycles.
REQ-019 idleCount SHALL reset to 0 whenever synced cki is high, otherwise increment, saturating at LATCH_CYCLES.
REQ-020 When idleCount reaches LATCH_CYCLES-1 and bitCount == 24, rgb SHALL load shiftReg and rgbValid SHALL pulse for exactly one cycle.
REQ-021 When idleCount reaches LATCH_CYCLES-1 and 0 < bitCount < 24, rgb SHALL hold its value, frameError SHALL pulse for one cycle, and shiftReg SHALL be discarded.
REQ-022 At any latch event, bitCount, shiftReg and forwarding SHALL clear in the same cycle.
REQ-023 When idleCount reaches LATCH_CYCLES-1 and bitCount == 0, no pulse SHALL occur and state SHALL be unchanged.
REQ-024 If ckiRise coincides with a latch event, the cki high resets idleCount first, so the latch SHALL NOT fire and the bit SHALL be accepted.
REQ-025 A cki high period shorter than one clk cycle is outside the operating range; behaviour is undefined but SHALL NOT deadlock.

Reset
REQ-026 While rst is low, all of the following SHALL be 0: synchronizers, shiftReg, bitCount, idleCount, forwarding, rgb, rgbValid, frameError, cko and sdo.
REQ-027 Reset asserted mid-word SHALL discard the word; after release, the next ckiRise SHALL be treated as bit 23 of a new word.

Structure
REQ-028 Package ws2801_pkg SHALL hold RGB_BITS=24, typedef rgb_t (logic [23:0]), and the default latch-cycle constant; the existing LED driver shares this package.
REQ-029 One sub-module, sync_ff (parameterized depth, asynchronous active-low reset), SHALL be instantiated for cki and for sdi.
REQ-030 bitCount SHALL be 5 bits; idleCount width SHALL be $clog2(LATCH_CYCLES+1).

Verification
REQ-031 Send 24 bits of 0xFFDF00, then hold cki low for 6250 cycles -> rgb=0xFFDF00, one rgbValid pulse, cko stays 0 throughout.
REQ-032 Chain 50 instances and send 0x000000, then 20x 0x3700FF, then 29x 0xFFDF00 -> after latch, LED0=0x000000, LEDs 1-20=0x3700FF, LEDs 21-49=0xFFDF00.
REQ-033 Send 10 bits, then idle 6250 cycles -> frameError pulses once, rgb unchanged, bitCount=0, and the next 24-bit word latches correctly.
REQ-034 Send 48 bits (0x123456 then 0xABCDEF) -> rgb=0x123456, and sdo/cko carry exactly 24 pulses encoding 0xABCDEF.
REQ-035 Idle 6249 cycles mid-frame, then resume cki -> no latch, frame continues; 24-bit word latches only after the full 6250-cycle gap.
REQ-036 Assert rst after 12 bits -> all outputs read 0 within 1 cycle; after release, a fresh 24-bit word latches intact.

Source files
------------

// File: rtl/ws2801_pkg.sv
// Shared WS2801 definitions used by the receiver and the LED driver.
package ws2801_pkg;

    // Bits per LED colour word (8 bits each of three channels).
    localparam int RGB_BITS = 24;

    // Continuous cki-low cycles that mark the end of a frame (500 us at 12.5 MHz).
    localparam int LATCH_CYCLES_DEFAULT = 6250;

    typedef logic [RGB_BITS-1:0] rgb_t;

endpackage

// File: rtl/ws2801_receiver_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Shift the raw input one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    // Synchronizer flops, cleared while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/ws2801_receiver.sv
// WS2801 LED receiver: captures the first 24 serial bits of a frame, forwards
// every later bit downstream, and latches the colour after a long cki-low gap.
module ws2801_receiver
    import ws2801_pkg::*;
#(
    parameter int LATCH_CYCLES = LATCH_CYCLES_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cki,
    input  logic sdi,
    output logic cko,
    output logic sdo,
    output rgb_t rgb,
    output logic rgbValid,
    output logic frameError
);

    localparam int                IDLE_W   = $clog2(LATCH_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(LATCH_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ARM = IDLE_W'(LATCH_CYCLES - 1);
    localparam logic [4:0]        BIT_FULL = 5'(RGB_BITS);
    localparam logic [4:0]        BIT_LAST = 5'(RGB_BITS - 1);

    logic              cki_s;
    logic              sdi_s;
    logic              cki_rise;
    logic              latch_evt;
    logic              fwd_pulse;

    logic              cki_prev_q,    cki_prev_d;
    rgb_t              shift_reg_q,   shift_reg_d;
    logic [4:0]        bit_count_q,   bit_count_d;
    logic [IDLE_W-1:0] idle_count_q,  idle_count_d;
    logic              forwarding_q,  forwarding_d;
    logic              pulse_fwd_q,   pulse_fwd_d;
    rgb_t              rgb_q,         rgb_d;
    logic              rgb_valid_q,   rgb_valid_d;
    logic              frame_error_q, frame_error_d;
    logic              cko_q,         cko_d;
    logic              sdo_q,         sdo_d;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_cki (
        .clk   (clk),
        .rst_n (rst),
        .d     (cki),
        .q     (cki_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sdi (
        .clk   (clk),
        .rst_n (rst),
        .d     (sdi),
        .q     (sdi_s)
    );

    // Next-state logic: bit capture, idle timing, latch decisions and forwarding.
    always_comb begin
        cki_rise  = cki_s & ~cki_prev_q;
        // A high cki clears the idle timer first, so a coincident rise blocks the latch.
        latch_evt = ~cki_s && (idle_count_q == IDLE_ARM);

        cki_prev_d    = cki_s;
        shift_reg_d   = shift_reg_q;
        bit_count_d   = bit_count_q;
        idle_count_d  = idle_count_q;
        forwarding_d  = forwarding_q;
        rgb_d         = rgb_q;
        rgb_valid_d   = 1'b0;
        frame_error_d = 1'b0;

        if (cki_s) begin
            idle_count_d = '0;
        end else if (idle_count_q != IDLE_MAX) begin
            idle_count_d = idle_count_q + 1'b1;
        end

        if (cki_rise && (bit_count_q != BIT_FULL)) begin
            shift_reg_d = {shift_reg_q[RGB_BITS-2:0], sdi_s};
            bit_count_d = bit_count_q + 5'd1;
            if (bit_count_q == BIT_LAST) begin
                forwarding_d = 1'b1;
            end
        end

        // An idle gap with no bits received leaves everything untouched.
        if (latch_evt && (bit_count_q != 5'd0)) begin
            if (bit_count_q == BIT_FULL) begin
                rgb_d       = shift_reg_q;
                rgb_valid_d = 1'b1;
            end else begin
                frame_error_d = 1'b1;
            end
            shift_reg_d  = '0;
            bit_count_d  = 5'd0;
            forwarding_d = 1'b0;
        end

        // Only pulses whose rising edge arrives after forwarding is set go downstream;
        // this keeps the tail of the 24th bit's own pulse off cko.
        fwd_pulse   = cki_rise ? forwarding_q : pulse_fwd_q;
        pulse_fwd_d = cki_s & fwd_pulse;
        cko_d       = forwarding_q & cki_s & fwd_pulse;
        sdo_d       = forwarding_q ? sdi_s : 1'b0;
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cki_prev_q    <= 1'b0;
            shift_reg_q   <= '0;
            bit_count_q   <= 5'd0;
            idle_count_q  <= '0;
            forwarding_q  <= 1'b0;
            pulse_fwd_q   <= 1'b0;
            rgb_q         <= '0;
            rgb_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            cko_q         <= 1'b0;
            sdo_q         <= 1'b0;
        end else begin
            cki_prev_q    <= cki_prev_d;
            shift_reg_q   <= shift_reg_d;
            bit_count_q   <= bit_count_d;
            idle_count_q  <= idle_count_d;
            forwarding_q  <= forwarding_d;
            pulse_fwd_q   <= pulse_fwd_d;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= rgb_valid_d;
            frame_error_q <= frame_error_d;
            cko_q         <= cko_d;
            sdo_q         <= sdo_d;
        end
    end

    assign cko        = cko_q;
    assign sdo        = sdo_q;
    assign rgb        = rgb_q;
    assign rgbValid   = rgb_valid_q;
    assign frameError = frame_error_q;

endmodule
